timer_match_unit: RTL

Control and compare stage that sits beside the free-running up-counter (load/enable/limit counter) and forms a programmable timer with it. It generates the counter's count-enable through a prescaler and its parallel load, and reads back the counter value. On a match against a programmable compare value it raises a level interrupt held until acknowledged. It runs in periodic (auto-reload) or one-shot mode.

---
 rtl/timer_match_unit_if.sv | 36 +++
 rtl/timer_match_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/timer_match_unit_if.sv
// timer_match_unit_if: groups the configuration, control, counter-side and
// interrupt signals of the timer compare stage. The master side configures
// the timer and closes the loop through the external counter. The slave
// side is the compare stage itself.
interface timer_match_unit_if #(
   parameter int DATA_WIDTH = 16,
   parameter int PSC_WIDTH  = 8
);
   logic                  cfg_we;
   logic [DATA_WIDTH-1:0] cfg_cmp;
   logic [DATA_WIDTH-1:0] cfg_reload;
   logic [PSC_WIDTH-1:0]  cfg_psc;
   logic                  cfg_oneshot;
   logic                  start;
   logic                  stop;
   logic [DATA_WIDTH-1:0] cnt_q;
   logic                  cnt_ce;
   logic                  cnt_pe;
   logic [DATA_WIDTH-1:0] cnt_d;
   logic                  irq;
   logic                  irq_ack;
   logic                  running;
   logic [7:0]            ovr_cnt;

   modport master (
      output cfg_we, cfg_cmp, cfg_reload, cfg_psc, cfg_oneshot,
      output start, stop, irq_ack, cnt_q,
      input  cnt_ce, cnt_pe, cnt_d, irq, running, ovr_cnt
   );

   modport slave (
      input  cfg_we, cfg_cmp, cfg_reload, cfg_psc, cfg_oneshot,
      input  start, stop, irq_ack, cnt_q,
      output cnt_ce, cnt_pe, cnt_d, irq, running, ovr_cnt
   );
endinterface

// File: rtl/timer_match_unit.sv
// timer_match_unit: prescaled control and compare stage for an external
// load/enable up-counter. It drives the counter's count-enable and
// parallel-load, then raises a level interrupt on a compare match. The
// interrupt stays high until it is acknowledged. The timer runs in periodic
// (auto-reload) or one-shot mode.
// Optional feature macro: TIMER_MATCH_OVR_EN adds a saturating count of
// matches lost while the interrupt was still pending.
module timer_match_unit #(
   parameter int DATA_WIDTH = 16,
   parameter int PSC_WIDTH  = 8
) (
   input logic               clk,
   input logic               rstn,
   timer_match_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [PSC_WIDTH-1:0]  psc_cnt_q, psc_cnt_d;
   logic [DATA_WIDTH-1:0] cmp_q, reload_q;
   logic [PSC_WIDTH-1:0]  psc_q;
   logic                  oneshot_q;
   logic                  irq_q, irq_d;
   logic                  tick, match;

   // A tick is one prescaled count slot. A match is a tick that finds the counter at the compare value.
   assign tick  = (state_q == RUN) && (psc_cnt_q == psc_q);
   assign match = tick && (bus.cnt_q == cmp_q);

   assign bus.cnt_ce  = tick && !match;
   assign bus.cnt_pe  = (state_q == LOAD) || (match && !oneshot_q);
   assign bus.cnt_d   = reload_q;
   assign bus.running = (state_q != IDLE);
   assign bus.irq     = irq_q;

   // Configuration registers: a write becomes visible the cycle after the strobe.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cmp_q     <= '1;
         reload_q  <= '0;
         psc_q     <= '0;
         oneshot_q <= 1'b0;
      end else if (bus.cfg_we) begin
         cmp_q     <= bus.cfg_cmp;
         reload_q  <= bus.cfg_reload;
         psc_q     <= bus.cfg_psc;
         oneshot_q <= bus.cfg_oneshot;
      end
   end

   // Next-state logic: stop overrides everything, start (re)arms through LOAD, and a one-shot match drops back to IDLE.
   always_comb begin
      state_d   = state_q;
      psc_cnt_d = psc_cnt_q;
      case (state_q)
         IDLE: begin
            psc_cnt_d = '0;
            if (bus.start) state_d = LOAD;
         end
         LOAD: begin
            psc_cnt_d = '0;
            state_d   = RUN;
         end
         RUN: begin
            psc_cnt_d = tick ? '0 : psc_cnt_q + PSC_WIDTH'(1);
            if (bus.start) begin
               state_d = LOAD;
            end else if (match && oneshot_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            psc_cnt_d = '0;
         end
      endcase
      if (bus.stop) state_d = IDLE;
   end

   // Timer state and prescaler registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         psc_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         psc_cnt_q <= psc_cnt_d;
      end
   end

   // A match sets the interrupt. An acknowledge clears it, except when a match arrives in the same cycle.
   assign irq_d = match | (irq_q & ~bus.irq_ack);

   // Interrupt level register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) irq_q <= 1'b0;
      else       irq_q <= irq_d;
   end

`ifdef TIMER_MATCH_OVR_EN
   logic [7:0] ovr_q, ovr_d;

   // Overrun count: matches that hit an unacknowledged interrupt, saturating at 255 and cleared by an acknowledge.
   always_comb begin
      ovr_d = ovr_q;
      if (bus.irq_ack) begin
         ovr_d = '0;
      end else if (match && irq_q && (ovr_q != 8'hFF)) begin
         ovr_d = ovr_q + 8'd1;
      end
   end

   // Overrun counter register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) ovr_q <= '0;
      else       ovr_q <= ovr_d;
   end

   assign bus.ovr_cnt = ovr_q;
`else
   assign bus.ovr_cnt = 8'd0;
`endif

endmodule
